// File: rtl/lsd_sequencer_pkg.sv
// Shared opcode, flag-index and FSM encodings for the accumulator program sequencer.
// Pure definitions: no latency, no flow control.
package lsd_sequencer_pkg;

    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_JN   = 4'hB;
    localparam logic [3:0] OP_JV   = 4'hC;
    localparam logic [3:0] OP_NOP  = 4'hD;
    localparam logic [3:0] OP_WAIT = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [11:0] IR_RST = {OP_NOP, 8'h00};

    function automatic logic is_alu_op(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/lsd_sequencer_if.sv
// ROM fetch and datapath control bundle between sequencer (master) and ROM/datapath (slave).
// Pure wiring: no latency, no flow control.
interface lsd_sequencer_if #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
);
    logic [PC_W-1:0]   pc_addr;
    logic [11:0]       instr;
    logic [3:0]        flags;
    logic              dp_en;
    logic [2:0]        dp_opr;
    logic [DATA_W-1:0] dp_b;

    modport master (
        output pc_addr, dp_en, dp_opr, dp_b,
        input  instr, flags
    );

    modport slave (
        input  pc_addr, dp_en, dp_opr, dp_b,
        output instr, flags
    );
endinterface

// File: rtl/lsd_sequencer_branch_cond.sv
// Branch condition evaluator: low opcode bits of a jump plus datapath flags -> taken.
// Combinational, no flow control.
module lsd_sequencer_branch_cond
    import lsd_sequencer_pkg::*;
(
    input  logic [2:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case ({1'b1, cond_i})
            OP_JMP:  taken_o = 1'b1;
            OP_JZ:   taken_o = flags_i[FLAG_Z];
            OP_JC:   taken_o = flags_i[FLAG_C];
            OP_JN:   taken_o = flags_i[FLAG_N];
            OP_JV:   taken_o = flags_i[FLAG_V];
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/lsd_sequencer.sv
// Program sequencer: fetches 12-bit instructions from async ROM, drives datapath en/OPR/B, branches on FLAGS.
// Two cycles per instruction (FETCH, EXEC); WAIT stalls in EXEC until go; start ignored while busy.
module lsd_sequencer
    import lsd_sequencer_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic go_i,
    lsd_sequencer_if.master bus,
    output logic busy_o,
    output logic halted_o
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [11:0]       ir_q, ir_d;
    logic [3:0]        op;
    logic              taken;

    assign op = ir_q[11:8];

    lsd_sequencer_branch_cond u_branch_cond (
        .cond_i  (op[2:0]),
        .flags_i (bus.flags),
        .taken_o (taken)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= IR_RST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                ir_d    = bus.instr;
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                if (!is_alu_op(op)) begin
                    case (op)
                        OP_NOP:  ;
                        OP_WAIT: if (!go_i) state_d = ST_EXEC;
                        OP_HALT: state_d = ST_HALT;
                        // Remaining control opcodes are the jumps; upper imm bits beyond PC_W are dropped.
                        default: if (taken) pc_d = ir_q[PC_W-1:0];
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.pc_addr = pc_q;
    assign bus.dp_en   = (state_q == ST_EXEC) && is_alu_op(op);
    assign bus.dp_opr  = ir_q[10:8];
    assign bus.dp_b    = ir_q[DATA_W-1:0];
    assign busy_o      = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign halted_o    = (state_q == ST_HALT);

endmodule

// File: tb/tb_lsd_sequencer.sv
// Directed bench for lsd_sequencer: an 8-bit-PC instance for program tests and a 3-bit-PC instance for wrap.
module tb_lsd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, go, start3;
    logic [3:0]  flags;
    logic        busy, halted, busy3, halted3;
    logic [11:0] rom  [256];
    logic [11:0] rom3 [8];

    lsd_sequencer_if #(.PC_W(8), .DATA_W(8)) bus ();
    lsd_sequencer_if #(.PC_W(3), .DATA_W(8)) bus3 ();

    assign bus.instr  = rom[bus.pc_addr];
    assign bus.flags  = flags;
    assign bus3.instr = rom3[bus3.pc_addr];
    assign bus3.flags = 4'h0;

    lsd_sequencer #(.PC_W(8), .DATA_W(8)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .go_i     (go),
        .bus      (bus.master),
        .busy_o   (busy),
        .halted_o (halted)
    );

    lsd_sequencer #(.PC_W(3), .DATA_W(8)) dut3 (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start3),
        .go_i     (1'b0),
        .bus      (bus3.master),
        .busy_o   (busy3),
        .halted_o (halted3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 12'hF00;
    endtask

    // Pulse start, then step until HALT or the cycle budget runs out.
    task automatic run(input int max, output int cyc, output int en_cnt,
                       output logic [2:0] opr, output logic [7:0] b);
        cyc = 0; en_cnt = 0; opr = '0; b = '0;
        start = 1'b1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (bus.dp_en) begin
                en_cnt++;
                opr = bus.dp_opr;
                b   = bus.dp_b;
            end
            if (halted) break;
        end
    endtask

    int         cyc, en_cnt;
    logic [2:0] opr;
    logic [7:0] b;
    logic [3:0] op, mask;

    initial begin
        rst = 1'b1; start = 1'b0; go = 1'b0; start3 = 1'b0; flags = 4'h0;
        clear_rom();
        for (int i = 0; i < 8; i++) rom3[i] = 12'hD00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_pc",     bus.pc_addr, 0);
        chk("rst_en",     bus.dp_en, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_opr",    bus.dp_opr, 3'd5);
        chk("rst_pc3",    bus3.pc_addr, 0);

        // Reset while an ALU op is in EXEC
        rom[0] = 12'h305;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("t1_en_pre", bus.dp_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t1_en",     bus.dp_en, 0);
        chk("t1_pc",     bus.pc_addr, 0);
        chk("t1_busy",   busy, 0);
        chk("t1_halted", halted, 0);
        rst = 1'b0;
        @(negedge clk);

        // ALU then HALT
        rom[0] = 12'h005;
        run(20, cyc, en_cnt, opr, b);
        chk("t2_halted", halted, 1);
        chk("t2_busy",   busy, 0);
        chk("t2_en_cnt", en_cnt, 1);
        chk("t2_opr",    opr, 0);
        chk("t2_b",      b, 8'h05);
        chk("t2_cycles", cyc, 5);
        chk("t2_pc",     bus.pc_addr, 2);

        // JZ taken / not taken
        clear_rom();
        rom[0] = 12'h000;
        rom[1] = 12'h907;
        flags = 4'b0001;
        run(20, cyc, en_cnt, opr, b);
        chk("t3_taken_pc", bus.pc_addr, 8);
        flags = 4'b0000;
        run(20, cyc, en_cnt, opr, b);
        chk("t3_untaken_pc", bus.pc_addr, 3);

        // JMP/JZ/JC/JN/JV with own flag set, then all other flags set
        for (int k = 0; k < 5; k++) begin
            op = 4'h8 + 4'(k);
            rom[1] = {op, 8'h07};
            mask = (k == 0) ? 4'h0 : 4'(1 << (k - 1));
            flags = mask;
            run(20, cyc, en_cnt, opr, b);
            chk($sformatf("t4_op%0h_set", op), bus.pc_addr, 8);
            flags = ~mask;
            run(20, cyc, en_cnt, opr, b);
            chk($sformatf("t4_op%0h_clr", op), bus.pc_addr, (k == 0) ? 8 : 3);
        end
        flags = 4'h0;

        // WAIT released by go
        rom[0] = 12'hE00;
        rom[1] = 12'hF00;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_busy%0d", i), busy, 1);
            chk($sformatf("t5_en%0d", i), bus.dp_en, 0);
            @(negedge clk);
        end
        chk("t5_wait_pc", bus.pc_addr, 1);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("t5_fetch_pc",   bus.pc_addr, 1);
        chk("t5_fetch_busy", busy, 1);
        @(negedge clk);
        chk("t5_exec_pc", bus.pc_addr, 2);
        @(negedge clk);
        chk("t5_halted", halted, 1);

        // 3-bit PC wraps; start while busy is ignored
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("t6_pc%0d", k), bus3.pc_addr, k % 8);
            chk($sformatf("t6_busy%0d", k), busy3, 1);
            start3 = (k >= 3 && k <= 5);
            @(negedge clk);
            chk($sformatf("t6_en%0d", k), bus3.dp_en, 0);
            @(negedge clk);
        end
        start3 = 1'b0;
        chk("t6_opr", bus3.dp_opr, 3'd5);
        chk("t6_b",   bus3.dp_b, 8'h00);
        chk("t6_halted", halted3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
